// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the dino game sequencer: game state encoding, score
// and speed widths, the default score ceiling, and a small max() helper.
// -----------------------------------------------------------------------------
package dino_pkg;

   localparam int SCORE_W   = 14;
   localparam int SPEED_W   = 4;
   localparam int SCORE_MAX = 9999;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } game_state_e;

   function automatic logic [SCORE_W-1:0] score_max(
      input logic [SCORE_W-1:0] a,
      input logic [SCORE_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dino_key_sampler.sv
// -----------------------------------------------------------------------------
// dino_key_sampler
// Brings the raw active-low jump button into the pixel clock domain, resamples
// it once per frame (which debounces it at frame rate) and flags a fresh press.
//
// Ports:
//   lcd_pclk    in  pixel clock
//   rst_n       in  asynchronous active-low reset
//   jump_key_n  in  raw jump button, active-low, asynchronous
//   frame_tick  in  one-cycle per-frame pulse
//   key_press   out pressed at this tick and released at the previous tick;
//                   only ever high in a frame_tick cycle
// -----------------------------------------------------------------------------
module dino_key_sampler (
   input  logic lcd_pclk,
   input  logic rst_n,
   input  logic jump_key_n,
   input  logic frame_tick,
   output logic key_press
);

   // Key is carried as active-high "pressed" so every flag resets to 0.
   logic key_meta;
   logic key_sync;
   logic key_last;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source, independent of statement order.
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 1'b0;
         key_sync <= 1'b0;
      end else begin
         key_meta <= ~jump_key_n;
         key_sync <= key_meta;
      end
   end

   // Frame-rate resample: key_last holds the level seen at the previous tick.
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         key_last <= 1'b0;
      end else if (frame_tick) begin
         key_last <= key_sync;
      end
   end

   assign key_press = frame_tick & key_sync & ~key_last;

endmodule

// File: rtl/dino_game_ctrl.sv
// -----------------------------------------------------------------------------
// dino_game_ctrl
// Frame-rate game sequencer for the dino LCD pipeline. Generates a per-frame
// tick from the scan position, latches dino/cactus overlap during the scan,
// samples the jump key and runs the IDLE/RUN/DEAD game state machine.
//
// Ports:
//   lcd_pclk, rst_n            pixel clock, asynchronous active-low reset
//   pixel_xpos, pixel_ypos     current scan position
//   h_disp, v_disp             active frame size
//   dino_draw                  dino pixel at current position
//   cactus_draw, cactus_draw_2 cactus pixels at current position
//   jump_key_n                 raw jump button, active-low
//   frame_tick                 one-cycle pulse, cycle after the last pixel
//   game_state                 0 IDLE, 1 RUN, 2 DEAD
//   run_en / game_over         registered RUN / DEAD indicators
//   jump_req                   one-cycle jump pulse, cycle after a tick
//   scroll_speed               ground/cactus step in px per frame
//   score / hi_score           current score and best since reset
// -----------------------------------------------------------------------------
module dino_game_ctrl
   import dino_pkg::*;
#(
   parameter int SCORE_DIV  = 6,
   parameter int SPEED_INIT = 2,
   parameter int SPEED_MAX  = 8,
   parameter int SPEED_STEP = 100,
   parameter int DEAD_HOLD  = 30,
   parameter int SCORE_MAX  = dino_pkg::SCORE_MAX
) (
   input  logic               lcd_pclk,
   input  logic               rst_n,
   input  logic [10:0]        pixel_xpos,
   input  logic [10:0]        pixel_ypos,
   input  logic [10:0]        h_disp,
   input  logic [10:0]        v_disp,
   input  logic               dino_draw,
   input  logic               cactus_draw,
   input  logic               cactus_draw_2,
   input  logic               jump_key_n,
   output logic               frame_tick,
   output logic [1:0]         game_state,
   output logic               run_en,
   output logic               jump_req,
   output logic [SPEED_W-1:0] scroll_speed,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] hi_score,
   output logic               game_over
);

   // ---------------------------------------------------------------- checks
   if (SCORE_DIV < 1 || SCORE_DIV > 64) begin : g_bad_score_div
      $error("SCORE_DIV must be 1..64 to fit the 6-bit divider");
   end
   if (SPEED_STEP < 1 || SPEED_STEP > 1024) begin : g_bad_speed_step
      $error("SPEED_STEP must be 1..1024 to fit the 10-bit step counter");
   end
   if (DEAD_HOLD < 0 || DEAD_HOLD > 63) begin : g_bad_dead_hold
      $error("DEAD_HOLD must be 0..63 to fit the 6-bit hold counter");
   end
   if (SPEED_MAX < 0 || SPEED_MAX >= (1 << SPEED_W) ||
       SPEED_INIT < 0 || SPEED_INIT > SPEED_MAX) begin : g_bad_speed
      $error("SPEED_INIT/SPEED_MAX must satisfy 0 <= INIT <= MAX < 2**SPEED_W");
   end
   if (SCORE_MAX < 0 || SCORE_MAX >= (1 << SCORE_W)) begin : g_bad_score_max
      $error("SCORE_MAX must fit in SCORE_W bits");
   end

   localparam logic [5:0]         DIV_LAST  = 6'(SCORE_DIV - 1);
   localparam logic [9:0]         STEP_LAST = 10'(SPEED_STEP - 1);
   localparam logic [5:0]         HOLD_V    = 6'(DEAD_HOLD);
   localparam logic [SPEED_W-1:0] SPD_INIT  = SPEED_W'(SPEED_INIT);
   localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);
   localparam logic [SCORE_W-1:0] SCR_MAX   = SCORE_W'(SCORE_MAX);

   // ------------------------------------------------------------ frame tick
   logic last_pixel;
   assign last_pixel = (pixel_xpos == h_disp - 11'd1) &&
                       (pixel_ypos == v_disp - 11'd1);

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) frame_tick <= 1'b0;
      else        frame_tick <= last_pixel;
   end

   // ------------------------------------------------------------- collision
   // Sticky for the whole frame; the tick cycle still sees this frame's value
   // and the flag is cleared on the edge that ends the tick cycle.
   logic hit_flag;

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         hit_flag <= 1'b0;
      end else if (frame_tick) begin
         hit_flag <= 1'b0;
      end else if (dino_draw && (cactus_draw || cactus_draw_2)) begin
         hit_flag <= 1'b1;
      end
   end

   // -------------------------------------------------------------- key path
   logic key_press;

   dino_key_sampler u_key_sampler (
      .lcd_pclk   (lcd_pclk),
      .rst_n      (rst_n),
      .jump_key_n (jump_key_n),
      .frame_tick (frame_tick),
      .key_press  (key_press)
   );

   // ------------------------------------------------------------------- FSM
   game_state_e        state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] hi_q, hi_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [5:0]         div_q, div_d;
   logic [9:0]         step_q, step_d;
   logic [5:0]         hold_q, hold_d;
   logic               jump_d;
   logic               start_game;

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      hi_d       = hi_q;
      speed_d    = speed_q;
      div_d      = div_q;
      step_d     = step_q;
      hold_d     = hold_q;
      jump_d     = 1'b0;
      start_game = 1'b0;

      if (frame_tick) begin
         case (state_q)
            ST_IDLE: begin
               // The starting press only starts the game; it is not a jump.
               if (key_press) start_game = 1'b1;
            end

            ST_RUN: begin
               if (hit_flag) begin
                  // Death wins over a same-tick press and over scoring.
                  state_d = ST_DEAD;
                  hold_d  = '0;
                  hi_d    = score_max(hi_q, score_q);
               end else begin
                  jump_d = key_press;
                  if (div_q == DIV_LAST) begin
                     div_d = '0;
                     // Saturated score freezes the speed ramp as well.
                     if (score_q < SCR_MAX) begin
                        score_d = score_q + 1'b1;
                        if (step_q == STEP_LAST) begin
                           step_d = '0;
                           if (speed_q < SPD_MAX) speed_d = speed_q + 1'b1;
                        end else begin
                           step_d = step_q + 1'b1;
                        end
                     end
                  end else begin
                     div_d = div_q + 1'b1;
                  end
               end
            end

            ST_DEAD: begin
               if (hold_q < HOLD_V) hold_d = hold_q + 1'b1;
               // Compare the pre-increment count: the key unlocks only once
               // DEAD_HOLD ticks have fully elapsed.
               if (key_press && (hold_q >= HOLD_V)) start_game = 1'b1;
            end

            default: state_d = ST_IDLE;
         endcase

         if (start_game) begin
            state_d = ST_RUN;
            score_d = '0;
            speed_d = SPD_INIT;
            div_d   = '0;
            step_d  = '0;
         end
      end
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         score_q   <= '0;
         hi_q      <= '0;
         speed_q   <= SPD_INIT;
         div_q     <= '0;
         step_q    <= '0;
         hold_q    <= '0;
         jump_req  <= 1'b0;
         run_en    <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         hi_q      <= hi_d;
         speed_q   <= speed_d;
         div_q     <= div_d;
         step_q    <= step_d;
         hold_q    <= hold_d;
         jump_req  <= jump_d;
         // Decoded from next state so they change on the same edge as state.
         run_en    <= (state_d == ST_RUN);
         game_over <= (state_d == ST_DEAD);
      end
   end

   assign game_state   = state_q;
   assign score        = score_q;
   assign hi_score     = hi_q;
   assign scroll_speed = speed_q;

endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
- Frame-rate game sequencer for the dino LCD pipeline. Sits beside the pixel compositor on the same pixel clock.
- Derives a once-per-frame tick from the scan position and detects dino/cactus pixel overlap during the scan.
- Samples the jump key and runs the IDLE/RUN/DEAD state machine.
- Drives the enables, jump request, scroll speed and score that the sprite generators and the compositor consume.

Parameters:
- SCORE_DIV, 6: frame ticks per score point.
- SPEED_INIT, 2: scroll speed (px/frame) loaded at game start.
- SPEED_MAX, 8: saturation value of scroll speed.
- SPEED_STEP, 100: score points per +1 speed.
- DEAD_HOLD, 30: frame ticks after death during which the key is ignored.
- SCORE_MAX, 9999: score saturation value.

Ports:
- lcd_pclk  in  1  pixel clock; the block's only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- pixel_xpos  in  11  current scan x.
- pixel_ypos  in  11  current scan y.
- h_disp  in  11  active width.
- v_disp  in  11  active height.
- dino_draw  in  1  dino pixel at the current position.
- cactus_draw  in  1  cactus 1 pixel.
- cactus_draw_2  in  1  cactus 2 pixel.
- jump_key_n  in  1  raw jump button, active-low, asynchronous.
- frame_tick  out  1  one-cycle pulse per frame.
- game_state  out  2  current state: 0 IDLE, 1 RUN, 2 DEAD.
- run_en  out  1  high in RUN; sprite motion allowed.
- jump_req  out  1  one-cycle jump pulse to the dino sprite.
- scroll_speed  out  4  ground/cactus scroll step.
- score  out  14  binary score.
- hi_score  out  14  best score since reset.
- game_over  out  1  high in DEAD; the compositor shows the game-over overlay.

Behaviour:
- Reset (async, rst_n low): state IDLE; all pulses 0; run_en 0; game_over 0; score 0; hi_score 0; scroll_speed SPEED_INIT; all internal counters and flags 0.
- frame_tick: registered. It is asserted the cycle after pixel_xpos==h_disp-1 && pixel_ypos==v_disp-1, and is exactly 1 cycle wide.
- Key path:
  - 2-FF synchronizer on jump_key_n.
  - The synchronized level is resampled only on frame_tick, which debounces it at frame rate.
  - press = the sample taken at this tick is pressed and the sample taken at the previous tick was released.
  - press is valid only in the frame_tick cycle.
- Collision:
  - hit_flag sets on any cycle where dino_draw && (cactus_draw || cactus_draw_2).
  - hit_flag clears on the cycle after frame_tick.
  - The flag value seen at frame_tick is the value evaluated for that frame.
- All state transitions and counter updates happen only in frame_tick cycles.
- IDLE:
  - press → RUN.
  - On entering RUN: score=0, scroll_speed=SPEED_INIT, div_cnt=0, step_cnt=0, hit_flag cleared.
  - No jump_req is issued on the starting press.
- RUN:
  - If hit_flag → DEAD. In that tick there is no score increment and no jump_req.
  - On entering DEAD: hi_score=max(hi_score, score); hold_cnt=0.
  - Otherwise div_cnt++. When div_cnt==SCORE_DIV-1, div_cnt wraps to 0 and score increments, saturating at SCORE_MAX.
  - Each score increment bumps step_cnt. When step_cnt==SPEED_STEP-1, step_cnt wraps and scroll_speed++, saturating at SPEED_MAX.
  - While score is saturated, step_cnt and scroll_speed are frozen.
  - press (and no hit) → jump_req is high for the frame_tick+1 cycle only.
- DEAD:
  - hold_cnt++ per tick, saturating at DEAD_HOLD.
  - Presses are ignored while hold_cnt<DEAD_HOLD.
  - After that, press → RUN with the same start initialisation as from IDLE.
- Outputs:
  - run_en = (state==RUN).
  - game_over = (state==DEAD).
  - Both are registered and follow the state with 0 added latency beyond the state register.
- Simultaneous events: a hit and a press in the same RUN tick resolve as DEAD with no jump_req.
- Reset mid-frame or mid-game: immediate return to reset values. hi_score is also lost.
- Widths:
  - div_cnt is 6 bits, step_cnt 10 bits, hold_cnt 6 bits.
  - Parameter values must fit their counters; this is checked by elaboration assertion.

Decomposition:
- Shared package dino_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DEAD=2'd2;
  - SCORE_W=14 and SPEED_W=4;
  - SCORE_MAX.
- One sub-module, dino_key_sampler, contains the 2-FF synchronizer, the frame-rate resample and the press pulse.
- Frame tick, collision flag and FSM stay in the top.

Test Plan:
- Reset mid-RUN with score 37 → all outputs at reset values within 1 cycle of rst_n low; state IDLE after release.
- Small frame (h_disp=8, v_disp=4), key pressed for 2 frames in IDLE → game_state 1 after the first press tick, no jump_req, score 0, scroll_speed 2.
- RUN for 600 frames with no hit → score 100, scroll_speed 3. Force score to 9998 and run 12 frames → score holds 9999.
- RUN, dino_draw&cactus_draw_2 for 1 cycle mid-frame together with a press → at the next tick: game_state 2, game_over 1, no jump_req, hi_score = score.
- DEAD, press at hold tick 10 → ignored. Press after tick 30 → RUN, score 0, hi_score retained.
- RUN with the key held for 5 frames, then released, then pressed → exactly 2 jump_req pulses, each 1 cycle, at tick+1.
